// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state encodings, funct3 codes and size decode for the LSU
package lsu_pkg;

    typedef logic [1:0] lsu_state_t;

    localparam lsu_state_t ST_IDLE = 2'd0;
    localparam lsu_state_t ST_REQ  = 2'd1;
    localparam lsu_state_t ST_WAIT = 2'd2;
    localparam lsu_state_t ST_DONE = 2'd3;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    // Byte-enable pattern for an access of 2**sz bytes at lane 0
    function automatic logic [7:0] size_be(input logic [1:0] sz);
        case (sz)
            2'b00:   return 8'h01;
            2'b01:   return 8'h03;
            2'b10:   return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

    // Offset bits that must be zero for a naturally aligned access
    function automatic logic [2:0] size_off_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'b000;
            2'b01:   return 3'b001;
            2'b10:   return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - lane steering, misalignment check and load extension
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]               funct3_i,
    input  logic                     we_i,
    input  logic [$clog2(XLEN/8)-1:0] off_i,
    input  logic [XLEN-1:0]          wdata_i,
    output logic [XLEN/8-1:0]        be_o,
    output logic [XLEN-1:0]          wdata_o,
    output logic                     bad_o,
    input  logic [2:0]               ld_funct3_i,
    input  logic [$clog2(XLEN/8)-1:0] ld_off_i,
    input  logic [XLEN-1:0]          rdata_i,
    output logic [XLEN-1:0]          ldata_o
);

    localparam int   BW   = XLEN / 8;
    localparam logic IS32 = (XLEN == 32);

    logic            illegal;
    logic            misaligned;
    logic [XLEN-1:0] field;
    logic [XLEN-1:0] keep;
    logic            msb;

    assign illegal    = (funct3_i == 3'b111)
                      | (IS32 & ((funct3_i[1:0] == 2'b11) | (funct3_i == LWU) | (we_i & funct3_i[2])));
    assign misaligned = (3'(off_i) & size_off_mask(funct3_i[1:0])) != 3'b000;
    assign bad_o      = illegal | misaligned;

    assign be_o    = BW'(size_be(funct3_i[1:0])) << off_i;
    assign wdata_o = wdata_i << {off_i, 3'b000};

    assign field = rdata_i >> {ld_off_i, 3'b000};

    always_comb begin
        msb  = field[XLEN-1];
        keep = '1;
        case (ld_funct3_i[1:0])
            2'b00: begin msb = field[7];  keep = XLEN'(8'hFF);         end
            2'b01: begin msb = field[15]; keep = XLEN'(16'hFFFF);      end
            2'b10: begin msb = field[31]; keep = XLEN'(32'hFFFF_FFFF); end
            default: ;
        endcase
        ldata_o = (field & keep) | ({XLEN{msb & ~ld_funct3_i[2]}} & ~keep);
    end

endmodule

// File: rtl/lsu_stall.sv
// rtl/lsu_stall.sv - M-stage load/store unit with bus handshake, pipeline stall and timeout
module lsu_stall
    import lsu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int AW       = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MemReqM,
    input  logic                MemWriteM,
    input  logic [2:0]          Funct3M,
    input  logic [AW-1:0]       ALUResultM,
    input  logic [XLEN-1:0]     WriteDataM,
    output logic                StallM,
    output logic [XLEN-1:0]     LoadDataM,
    output logic                MisalignM,
    output logic                BusErr,
    output logic                bus_req,
    output logic                bus_we,
    output logic [AW-1:0]       bus_addr,
    output logic [XLEN/8-1:0]   bus_be,
    output logic [XLEN-1:0]     bus_wdata,
    input  logic                bus_gnt,
    input  logic                bus_rvalid,
    input  logic [XLEN-1:0]     bus_rdata
);

    localparam int BW = XLEN / 8;
    localparam int OW = $clog2(BW);
    localparam int CW = $clog2(MAX_WAIT + 1);

    lsu_state_t      state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            we_q, we_d;
    logic [BW-1:0]   be_q, be_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [OW-1:0]   off_q, off_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] ldata_q, ldata_d;
    logic            buserr_q, buserr_d;

    logic [BW-1:0]   be_new;
    logic [XLEN-1:0] wdata_new;
    logic [XLEN-1:0] ld_ext;
    logic            bad;
    logic            start;
    logic            timeout;

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3_i    (Funct3M),
        .we_i        (MemWriteM),
        .off_i       (ALUResultM[OW-1:0]),
        .wdata_i     (WriteDataM),
        .be_o        (be_new),
        .wdata_o     (wdata_new),
        .bad_o       (bad),
        .ld_funct3_i (funct3_q),
        .ld_off_i    (off_q),
        .rdata_i     (bus_rdata),
        .ldata_o     (ld_ext)
    );

    // Combinational outputs are gated by reset so they read 0 while it is held
    assign start     = (state_q == ST_IDLE) & MemReqM & ~bad;
    assign MisalignM = reset & MemReqM & bad;
    assign StallM    = reset & (start | (state_q == ST_REQ) | (state_q == ST_WAIT));
    assign timeout   = (cnt_q + CW'(1)) == CW'(MAX_WAIT);

    assign bus_req   = (state_q == ST_REQ);
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
    assign LoadDataM = ldata_q;
    assign BusErr    = buserr_q;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        cnt_d    = cnt_q;
        ldata_d  = ldata_q;
        buserr_d = buserr_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d   = {ALUResultM[AW-1:OW], {OW{1'b0}}};
                    we_d     = MemWriteM;
                    be_d     = be_new;
                    wdata_d  = wdata_new;
                    funct3_d = Funct3M;
                    off_d    = ALUResultM[OW-1:0];
                    cnt_d    = '0;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + CW'(1);
                if (bus_gnt && bus_rvalid) begin
                    ldata_d = we_q ? '0 : ld_ext;
                    state_d = ST_DONE;
                end else if (timeout) begin
                    ldata_d  = '0;
                    buserr_d = 1'b1;
                    state_d  = ST_DONE;
                end else if (bus_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (bus_rvalid) begin
                    ldata_d = we_q ? '0 : ld_ext;
                    state_d = ST_DONE;
                end else if (timeout) begin
                    ldata_d  = '0;
                    buserr_d = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            funct3_q <= '0;
            off_q    <= '0;
            cnt_q    <= '0;
            ldata_q  <= '0;
            buserr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
            cnt_q    <= cnt_d;
            ldata_q  <= ldata_d;
            buserr_q <= buserr_d;
        end
    end

endmodule

// File: tb/tb_lsu_stall.sv
// tb/tb_lsu_stall.sv - directed-vector bench for lsu_stall at XLEN=32 and XLEN=64
module tb_lsu_stall;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req32, req64, we, gnt32, rv32, gnt64, rv64;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [63:0] wd, rd;

    logic        stall32, mis32, err32, breq32, bwe32;
    logic [31:0] ld32, baddr32, bwd32;
    logic [3:0]  bbe32;
    logic        stall64, mis64, err64, breq64, bwe64;
    logic [63:0] ld64, bwd64;
    logic [31:0] baddr64;
    logic [7:0]  bbe64;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lsu_stall #(.XLEN(32), .AW(32), .MAX_WAIT(255)) u32 (
        .clk(clk), .reset(reset), .MemReqM(req32), .MemWriteM(we), .Funct3M(f3),
        .ALUResultM(addr), .WriteDataM(wd[31:0]), .StallM(stall32), .LoadDataM(ld32),
        .MisalignM(mis32), .BusErr(err32), .bus_req(breq32), .bus_we(bwe32),
        .bus_addr(baddr32), .bus_be(bbe32), .bus_wdata(bwd32), .bus_gnt(gnt32),
        .bus_rvalid(rv32), .bus_rdata(rd[31:0])
    );

    lsu_stall #(.XLEN(64), .AW(32), .MAX_WAIT(4)) u64 (
        .clk(clk), .reset(reset), .MemReqM(req64), .MemWriteM(we), .Funct3M(f3),
        .ALUResultM(addr), .WriteDataM(wd), .StallM(stall64), .LoadDataM(ld64),
        .MisalignM(mis64), .BusErr(err64), .bus_req(breq64), .bus_we(bwe64),
        .bus_addr(baddr64), .bus_be(bbe64), .bus_wdata(bwd64), .bus_gnt(gnt64),
        .bus_rvalid(rv64), .bus_rdata(rd)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        {req32, req64, we, gnt32, rv32, gnt64, rv64} = '0;
        f3 = 3'b000; addr = '0; wd = '0; rd = '0;
        #2;
        check_eq("rst_stall32", 64'(stall32), 64'd0);
        check_eq("rst_req32",   64'(breq32),  64'd0);
        check_eq("rst_err64",   64'(err64),   64'd0);
        check_eq("rst_ld64",    ld64,         64'd0);
        check_eq("rst_wdata64", bwd64,        64'd0);
        cyc(); reset = 1'b1;
        cyc();

        // sw 0xDEADBEEF @0x100, gnt at t+3, rvalid at t+4
        req32 = 1; we = 1; f3 = SW; addr = 32'h100; wd = 64'hDEADBEEF; #1;
        check_eq("sw_t_stall", 64'(stall32), 64'd1);
        check_eq("sw_t_req",   64'(breq32),  64'd0);
        cyc(); req32 = 0; #1;
        check_eq("sw_t1_req",   64'(breq32),  64'd1);
        check_eq("sw_t1_addr",  64'(baddr32), 64'h100);
        check_eq("sw_t1_be",    64'(bbe32),   64'hF);
        check_eq("sw_t1_wdata", 64'(bwd32),   64'hDEADBEEF);
        check_eq("sw_t1_we",    64'(bwe32),   64'd1);
        check_eq("sw_t1_stall", 64'(stall32), 64'd1);
        cyc(); #1;
        check_eq("sw_t2_req",   64'(breq32),  64'd1);
        check_eq("sw_t2_stall", 64'(stall32), 64'd1);
        cyc(); gnt32 = 1; #1;
        check_eq("sw_t3_req",   64'(breq32),  64'd1);
        check_eq("sw_t3_stall", 64'(stall32), 64'd1);
        cyc(); gnt32 = 0; rv32 = 1; #1;
        check_eq("sw_t4_req",   64'(breq32),  64'd0);
        check_eq("sw_t4_stall", 64'(stall32), 64'd1);
        cyc(); rv32 = 0; #1;
        check_eq("sw_done_stall", 64'(stall32), 64'd0);
        check_eq("sw_done_ld",    64'(ld32),    64'd0);
        cyc(); #1;
        check_eq("sw_idle_stall", 64'(stall32), 64'd0);
        check_eq("sw_idle_req",   64'(breq32),  64'd0);

        // lb / lbu @0x103 with rdata 0x80123456, gnt & rvalid at t+1
        for (int k = 0; k < 2; k++) begin
            req32 = 1; we = 0; f3 = (k == 0) ? LB : LBU; addr = 32'h103; #1;
            check_eq("lb_t_stall", 64'(stall32), 64'd1);
            cyc(); req32 = 0; gnt32 = 1; rv32 = 1; rd = 64'h80123456; #1;
            check_eq("lb_t1_stall", 64'(stall32), 64'd1);
            check_eq("lb_t1_be",    64'(bbe32),   64'h8);
            check_eq("lb_t1_addr",  64'(baddr32), 64'h100);
            cyc(); gnt32 = 0; rv32 = 0; #1;
            check_eq("lb_done_stall", 64'(stall32), 64'd0);
            check_eq("lb_done_ld", 64'(ld32), (k == 0) ? 64'hFFFFFF80 : 64'h00000080);
            cyc();
        end

        // sh 0x1234ABCD @0x102
        req32 = 1; we = 1; f3 = SH; addr = 32'h102; wd = 64'h1234ABCD; #1;
        check_eq("sh_t_stall", 64'(stall32), 64'd1);
        cyc(); req32 = 0; gnt32 = 1; rv32 = 1; #1;
        check_eq("sh_be",    64'(bbe32),   64'hC);
        check_eq("sh_wdata", 64'(bwd32),   64'hABCD0000);
        check_eq("sh_addr",  64'(baddr32), 64'h100);
        cyc(); gnt32 = 0; rv32 = 0; #1;
        check_eq("sh_done_stall", 64'(stall32), 64'd0);
        cyc();

        // misaligned and illegal accesses never reach the bus
        req32 = 0; we = 0; f3 = LW; addr = 32'h101; #1;
        check_eq("mis_noreq", 64'(mis32), 64'd0);
        req32 = 1; #1;
        check_eq("lw101_mis",   64'(mis32),   64'd1);
        check_eq("lw101_stall", 64'(stall32), 64'd0);
        cyc(); #1;
        check_eq("lw101_req",   64'(breq32),  64'd0);
        check_eq("lw101_stall2", 64'(stall32), 64'd0);
        f3 = LD; addr = 32'h100; #1;
        check_eq("ld32_illegal", 64'(mis32), 64'd1);
        f3 = LWU; #1;
        check_eq("lwu32_illegal", 64'(mis32), 64'd1);
        we = 1; f3 = 3'b100; #1;
        check_eq("st1xx_illegal", 64'(mis32), 64'd1);
        check_eq("st1xx_stall",   64'(stall32), 64'd0);
        we = 0; f3 = LW; addr = 32'h104; #1;
        check_eq("lw104_mis",   64'(mis32),   64'd0);
        check_eq("lw104_stall", 64'(stall32), 64'd1);
        cyc(); req32 = 0; gnt32 = 1; rv32 = 1; rd = 64'h7FFF0001; #1;
        cyc(); gnt32 = 0; rv32 = 0; #1;
        check_eq("lw104_ld", 64'(ld32), 64'h7FFF0001);
        cyc();

        // XLEN=64: ld @0x1008
        req64 = 1; we = 0; f3 = LD; addr = 32'h1008; #1;
        check_eq("ld64_stall", 64'(stall64), 64'd1);
        check_eq("ld64_mis",   64'(mis64),   64'd0);
        cyc(); req64 = 0; gnt64 = 1; rv64 = 1; rd = 64'h8123_4567_89AB_CDEF; #1;
        check_eq("ld64_addr", 64'(baddr64), 64'h1008);
        check_eq("ld64_be",   64'(bbe64),   64'hFF);
        check_eq("ld64_req",  64'(breq64),  64'd1);
        check_eq("ld64_we",   64'(bwe64),   64'd0);
        cyc(); gnt64 = 0; rv64 = 0; #1;
        check_eq("ld64_done_stall", 64'(stall64), 64'd0);
        check_eq("ld64_data", ld64, 64'h8123_4567_89AB_CDEF);
        cyc();

        // XLEN=64: lw @0x100C picks the upper word and sign-extends
        req64 = 1; f3 = LW; addr = 32'h100C; #1;
        cyc(); req64 = 0; gnt64 = 1; rv64 = 1; rd = 64'h8000_0000_1234_5678; #1;
        check_eq("lw64_be",   64'(bbe64),   64'hF0);
        check_eq("lw64_addr", 64'(baddr64), 64'h1008);
        cyc(); gnt64 = 0; rv64 = 0; #1;
        check_eq("lw64_data", ld64, 64'hFFFF_FFFF_8000_0000);
        cyc();

        // MAX_WAIT=4 with no grant: timeout after 4 REQ cycles
        req64 = 1; f3 = LW; addr = 32'h1000; #1;
        check_eq("to_t_stall", 64'(stall64), 64'd1);
        check_eq("to_t_err",   64'(err64),   64'd0);
        cyc(); req64 = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("to_req",   64'(breq64),  64'd1);
            check_eq("to_stall", 64'(stall64), 64'd1);
            cyc();
        end
        #1;
        check_eq("to_done_req",   64'(breq64),  64'd0);
        check_eq("to_done_stall", 64'(stall64), 64'd0);
        check_eq("to_done_err",   64'(err64),   64'd1);
        check_eq("to_done_ld",    ld64,         64'd0);
        cyc(); #1;
        check_eq("to_sticky_err", 64'(err64),   64'd1);
        check_eq("to_after_req",  64'(breq64),  64'd0);
        cyc();

        // reset asserted while u32 is in WAIT
        req32 = 1; we = 0; f3 = LW; addr = 32'h200; #1;
        cyc(); req32 = 0; gnt32 = 1; #1;
        check_eq("rw_req", 64'(breq32), 64'd1);
        cyc(); gnt32 = 0; #1;
        check_eq("rw_wait_stall", 64'(stall32), 64'd1);
        reset = 1'b0; #1;
        check_eq("rw_rst_stall", 64'(stall32), 64'd0);
        check_eq("rw_rst_req",   64'(breq32),  64'd0);
        check_eq("rw_rst_err64", 64'(err64),   64'd0);
        check_eq("rw_rst_err32", 64'(err32),   64'd0);
        cyc();
        cyc(); reset = 1'b1;
        rv32 = 1; rd = 64'hFFFF_FFFF; #1;
        check_eq("rw_rv_stall", 64'(stall32), 64'd0);
        cyc(); rv32 = 0; #1;
        check_eq("rw_post_stall", 64'(stall32), 64'd0);
        check_eq("rw_post_ld",    64'(ld32),    64'd0);
        check_eq("rw_post_req",   64'(breq32),  64'd0);
        cyc(); #1;
        check_eq("rw_post_stall2", 64'(stall32), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_stall.md
# lsu_stall

Parametrised load/store unit for the pipelined RISC-V core's Memory stage. Replaces the fixed single-cycle data-memory connection with a request/grant/response bus handshake of variable latency. It stalls the pipeline while a transaction is outstanding. It also handles byte/half/word/double lane steering, load sign extension, misalignment detection and a bus timeout.

## Interface
Parameters:
- XLEN, 32, data width; legal values 32 or 64.
- AW, 32, bus address width.
- MAX_WAIT, 255, maximum cycles spent in REQ+WAIT before a timeout; must be ≥1.

Ports:
- clk  in  1  core clock; everything is on the rising edge.
- reset  in  1  asynchronous, active-low (asserted at 0).
- MemReqM  in  1  M-stage instruction is a load or store.
- MemWriteM  in  1  1 = store, 0 = load.
- Funct3M  in  3  RISC-V size/sign field.
- ALUResultM  in  AW  byte address.
- WriteDataM  in  XLEN  store data, right-aligned.
- StallM  out  1  freeze F–M stages and bubble W.
- LoadDataM  out  XLEN  extended load result; valid in the DONE cycle.
- MisalignM  out  1  misaligned or illegal access, combinational.
- BusErr  out  1  sticky timeout flag.
- bus_req  out  1  request.
- bus_we  out  1  write enable.
- bus_addr  out  AW  lane-aligned address, low log2(XLEN/8) bits zero.
- bus_be  out  XLEN/8  byte enables.
- bus_wdata  out  XLEN  lane-shifted store data.
- bus_gnt  in  1  request accepted.
- bus_rvalid  in  1  response or write acknowledge.
- bus_rdata  in  XLEN  read data.

## Operation
- Lane offset `off` = ALUResultM[log2(XLEN/8)-1:0].
- Size is set by Funct3M[1:0]: 00 = byte, 01 = half, 10 = word, 11 = double.
  - 11 is illegal when XLEN=32.
  - Funct3M 111 is illegal.
  - Funct3M 110 (lwu) and store 1xx are illegal when XLEN=32.
- Misaligned when `off` is not a multiple of the size. MisalignM = MemReqM & (misaligned | illegal).
  - No bus request is issued and StallM=0.
  - The trap is handled elsewhere.
- bus_be = ((1<<size_bytes)-1) << off.
- bus_wdata = WriteDataM << 8*off.
- Load: field = bus_rdata >> 8*off, truncated to the access size.
  - Sign-extended when Funct3M[2]=0.
  - Zero-extended when Funct3M[2]=1.
- FSM states:
  - IDLE: MemReqM & !MisalignM → capture addr/we/be/wdata/funct3/off, go to REQ, StallM=1 this cycle. Otherwise stay. bus_rvalid is ignored.
  - REQ: bus_req=1, outputs taken from captured registers and held stable until bus_gnt.
    - gnt & rvalid → DONE.
    - gnt only → WAIT.
  - WAIT: bus_req=0; rvalid → DONE. Capture rdata on rvalid.
  - DONE: StallM=0; LoadDataM = extended captured data (0 for stores); go to IDLE. MemReqM is ignored in this cycle because the stalled instruction is still in M.
- Timeout: a counter, width clog2(MAX_WAIT+1), runs in REQ and WAIT.
  - On reaching MAX_WAIT it forces DONE with captured data 0, sets BusErr and drops bus_req.
  - BusErr clears only on reset.
- On reset: state IDLE, all outputs 0, counter 0. bus_req deasserts asynchronously. The in-flight transaction is abandoned and a later rvalid is ignored.

## Timing
- The request is detected in IDLE in cycle t. bus_req is asserted at t+1.
- Best case is gnt & rvalid at t+1: DONE at t+2. StallM is high in t and t+1, giving a minimum of 2 stall cycles.
- General case: StallM is high from t through the cycle rvalid is sampled, and is low in DONE.
- Data latency: LoadDataM is valid exactly in the DONE cycle, which is one cycle after rvalid. It is registered.
- Stall cycles: at most 1 + MAX_WAIT stall cycles per access.
- No back-to-back overlap: the earliest next request is IDLE at DONE+1, so there is at most one outstanding transaction.

## Structure
- Package lsu_pkg:
  - State enum (IDLE, REQ, WAIT, DONE).
  - Funct3 localparams (LB…LWU, SB…SD).
  - Size-decode function.
- Sub-module lsu_align, combinational:
  - Size/offset to bus_be, bus_wdata and misalignment.
  - rdata + off + funct3 to extended load data.
- lsu_stall holds the FSM, capture registers, timeout counter and BusErr.
- The core top instantiates lsu_stall in place of its direct data-memory connection. The hazard unit ORs StallM into the F/D/E/M enables and flushes W.

## Test plan
- XLEN=32, sw 0xDEADBEEF @0x100, gnt at t+3, rvalid at t+4: bus_addr=0x100, bus_be=4'hF, bus_wdata=0xDEADBEEF, bus_req held t+1..t+3, StallM high t..t+4, DONE at t+5.
- lb @0x103 with rdata 0x80123456 → LoadDataM=0xFFFFFF80. Same access as lbu → 0x00000080. gnt & rvalid at t+1 → StallM is exactly 2 cycles.
- sh 0x1234ABCD @0x102 → bus_be=4'b1100, bus_wdata=0xABCD0000. lw @0x101 → MisalignM=1, bus_req never rises, StallM=0.
- XLEN=64, ld @0x1008 → bus_addr=0x1008, bus_be=8'hFF. lw @0x100C with rdata[63:32]=0x80000000 → LoadDataM=0xFFFFFFFF80000000.
- MAX_WAIT=4, bus_gnt tied 0 → DONE after 4 REQ cycles, BusErr=1 sticky, LoadDataM=0, bus_req low from DONE onward.
- reset asserted in WAIT → bus_req, StallM and BusErr are 0 immediately, state IDLE. rvalid pulse after release → no DONE and no stall.
